// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak-f[1600] round sequencer
package keccak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NUM_ROUNDS = 24;
    localparam int ROUND_BASE = 1;
    localparam int RW         = 5;
    localparam int LANE_W     = 64;
    localparam int STATE_W    = 1600;

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - handshake and round-control bundle of the Keccak sequencer
interface keccak_round_ctrl_if #(
    parameter int RW = keccak_pkg::RW
);
    logic          in_valid;
    logic          in_ready;
    logic          stall;
    logic          abort;
    logic          load_en;
    logic          round_en;
    logic [RW-1:0] round_number;
    logic          busy;
    logic          out_valid;
    logic          out_ready;

    // Producer/consumer side: drives the block handshake and flow controls.
    modport master (
        output in_valid, stall, abort, out_ready,
        input  in_ready, load_en, round_en, round_number, busy, out_valid
    );

    // Controller side.
    modport slave (
        input  in_valid, stall, abort, out_ready,
        output in_ready, load_en, round_en, round_number, busy, out_valid
    );
endinterface

// File: rtl/keccak_round_counter.sv
// rtl/keccak_round_counter.sv - loadable round index counter with clear and terminal-count flag
module keccak_round_counter #(
    parameter int          RW     = 5,
    parameter logic [RW-1:0] TC_VAL = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [RW-1:0] i_load_val,
    input  logic          i_en,
    output logic [RW-1:0] o_count,
    output logic          o_tc
);
    logic [RW-1:0] r_count;

    // Clear has priority over load, load over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VAL);
endmodule

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - load/round/done sequencer for the one-round-per-clock Keccak core
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = keccak_pkg::NUM_ROUNDS,
    parameter int ROUND_BASE = keccak_pkg::ROUND_BASE,
    parameter int RW         = keccak_pkg::RW
) (
    input  logic                clk,
    input  logic                rst_n,
    keccak_round_ctrl_if.slave  bus
);
    import keccak_pkg::*;

    localparam logic [RW-1:0] W_FIRST = RW'(ROUND_BASE);
    localparam logic [RW-1:0] W_LAST  = RW'(ROUND_BASE + NUM_ROUNDS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_busy;
    logic          r_out_valid;
    logic          w_in_ready;
    logic          w_load_en;
    logic          w_round_en;
    logic          w_cnt_clr;
    logic          w_cnt_load;
    logic          w_cnt_en;
    logic          w_last_round;
    logic [RW-1:0] w_round_number;

    keccak_round_counter #(
        .RW     (RW),
        .TC_VAL (W_LAST)
    ) u_round_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (W_FIRST),
        .i_en       (w_cnt_en),
        .o_count    (w_round_number),
        .o_tc       (w_last_round)
    );

    // State register plus busy/out_valid registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state == ST_ROUND);
            r_out_valid <= (w_next_state == ST_DONE);
        end
    end

    // Next-state and strobe decode; abort overrides stall and completion.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_load_en    = 1'b0;
        w_round_en   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load_en    = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (bus.abort) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (!bus.stall) begin
                    w_round_en = 1'b1;
                    if (w_last_round) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (bus.out_ready) begin
                    w_in_ready = 1'b1;
                    if (bus.in_valid) begin
                        w_load_en    = 1'b1;
                        w_cnt_load   = 1'b1;
                        w_next_state = ST_ROUND;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.load_en      = w_load_en;
    assign bus.round_en     = w_round_en;
    assign bus.round_number = w_round_number;
    assign bus.busy         = r_busy;
    assign bus.out_valid    = r_out_valid;
endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - scoreboard bench for the Keccak round sequencer
module tb_keccak_round_ctrl;
    import keccak_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keccak_round_ctrl_if bus ();

    keccak_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic       ir;
        logic       ld;
        logic       re;
        logic [4:0] rn;
        logic       busy;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   checks      = 0;
    int   errors      = 0;
    bit   prop_en     = 1'b0;
    int   done_blocks = 0;
    string cur_tag    = "init";

    task automatic cyc(input logic iv, input logic st, input logic ab, input logic ordy,
                       input logic e_ir, input logic e_ld, input logic e_re, input int e_rn,
                       input logic e_busy, input logic e_ov);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.stall     = st;
        bus.abort     = ab;
        bus.out_ready = ordy;
        e.tag  = cur_tag;
        e.ir   = e_ir;
        e.ld   = e_ld;
        e.re   = e_re;
        e.rn   = 5'(e_rn);
        e.busy = e_busy;
        e.ov   = e_ov;
        q.push_back(e);
    endtask

    task automatic rounds(input int first, input int last);
        for (int k = first; k <= last; k++) cyc(0, 0, 0, 0, 0, 0, 1, k, 1, 0);
    endtask

    task automatic accept();
        cyc(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: scoreboard comparison each cycle plus invariants in random mode.
    logic prev_ov   = 1'b0;
    logic prev_ordy = 1'b0;
    int   rcnt      = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.in_ready !== e.ir || bus.load_en !== e.ld || bus.round_en !== e.re ||
                    bus.round_number !== e.rn || bus.busy !== e.busy || bus.out_valid !== e.ov) begin
                    errors++;
                    $display("FAIL %s: got ir=%b ld=%b re=%b rn=%0d busy=%b ov=%b, expected ir=%b ld=%b re=%b rn=%0d busy=%b ov=%b",
                             e.tag, bus.in_ready, bus.load_en, bus.round_en, bus.round_number, bus.busy,
                             bus.out_valid, e.ir, e.ld, e.re, e.rn, e.busy, e.ov);
                end
            end
            if (prop_en) begin
                checks++;
                if (bus.load_en && bus.round_en) begin
                    errors++;
                    $display("FAIL load_round_overlap: load_en=1 round_en=1, expected not both");
                end
                if (prev_ov && !prev_ordy) begin
                    checks++;
                    if (bus.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL out_valid_drop: got %b, expected 1", bus.out_valid);
                    end
                end
                if (bus.out_valid && !prev_ov) begin
                    checks++;
                    if (rcnt != NUM_ROUNDS) begin
                        errors++;
                        $display("FAIL rounds_per_block: got %0d, expected %0d", rcnt, NUM_ROUNDS);
                    end
                end
                if (bus.load_en) rcnt = 0;
                if (bus.round_en) rcnt++;
                if (bus.out_valid && bus.out_ready) done_blocks++;
            end
            prev_ov   = bus.out_valid;
            prev_ordy = bus.out_ready;
        end
    end

    initial begin
        int ncyc;
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.round_number !== 5'd0) begin
            errors++;
            $display("FAIL in_reset: got busy=%b ov=%b rn=%0d, expected 0 0 0",
                     bus.busy, bus.out_valid, bus.round_number);
        end
        rst_n = 1'b1;

        cur_tag = "t1_single_block";
        idle();
        accept();
        rounds(1, 24);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        idle();

        cur_tag = "t2_stall";
        accept();
        rounds(1, 9);
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 10, 1, 0);
        rounds(10, 24);

        cur_tag = "t3_done_hold";
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        rounds(1, 23);

        cur_tag = "t4_abort_last";
        cyc(0, 1, 1, 0, 0, 0, 0, 24, 1, 0);
        accept();

        cur_tag = "t4b_abort_done";
        rounds(1, 24);
        cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        cur_tag = "t4c_abort_idle";
        cyc(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);

        cur_tag = "t5_async_reset";
        rounds(1, 6);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.round_number !== 5'd7) begin
            errors++;
            $display("FAIL pre_reset_index: got %0d, expected 7", bus.round_number);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.round_number !== 5'd0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.round_en !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got rn=%0d busy=%b ov=%b ir=%b re=%b, expected 0 0 0 1 0",
                     bus.round_number, bus.busy, bus.out_valid, bus.in_ready, bus.round_en);
        end
        rst_n = 1'b1;
        q.push_back('{"t5_reset_cycle", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0});
        idle();
        idle();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end

        cur_tag = "t6_random";
        prop_en = 1'b1;
        ncyc    = 0;
        while (done_blocks < 1000 && ncyc < 90000) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.stall     = ($urandom_range(0, 7) == 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            ncyc++;
        end
        @(negedge clk);
        prop_en = 1'b0;
        checks++;
        if (done_blocks < 1000) begin
            errors++;
            $display("FAIL random_timeout: got %0d blocks, expected 1000", done_blocks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencer for the iterative Keccak-f[1600] permutation core, one round per clock. Accepts a block through a valid/ready handshake and issues a load strobe to the 1600-bit state register. Then steps the round index that addresses the round-constant ROM and drives the round-enable. Presents the result through a valid/ready handshake; supports stall and abort.

Parameters:
NUM_ROUNDS, 24, rounds per permutation.
ROUND_BASE, 1, first round index issued; ROM entries ROUND_BASE..ROUND_BASE+NUM_ROUNDS-1 hold RC[0..23], and index 0 is never issued.
RW, 5, width of round index; must satisfy ROUND_BASE+NUM_ROUNDS-1 < 2**RW.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  absorbed state block available.
in_ready  out  1  controller can accept a block.
stall  in  1  freeze round progression this cycle.
abort  in  1  synchronous cancel of current permutation.
load_en  out  1  capture input block into state register (first step).
round_en  out  1  apply one round (theta..iota) to state register.
round_number  out  RW  index to round-constant ROM.
busy  out  1  permutation in progress (load or rounds).
out_valid  out  1  permuted state valid.
out_ready  in  1  consumer takes permuted state.

Behaviour:
- States: IDLE, ROUND, DONE; encoding comes from the shared package.
- Reset (rst_n low, async): state=IDLE, round counter=0, all registered outputs 0. in_ready=1 as soon as reset releases in IDLE.
- Outputs in_ready, load_en and round_en are decoded from state; round_number, busy and out_valid are registered.
- IDLE:
  - in_ready=1, round_number=0.
  - When in_valid&in_ready: load_en=1 that cycle; next state ROUND with round_number=ROUND_BASE, busy=1.
- ROUND:
  - round_en = ~stall.
  - With ~stall: round_number increments by 1 each cycle.
  - When round_number==ROUND_BASE+NUM_ROUNDS-1 and ~stall: next state DONE, round_number->0, busy->0, out_valid->1.
  - With stall=1: round_en=0 and round_number/state hold, including on the last round.
- DONE:
  - out_valid=1 held until out_ready. out_valid must not drop without out_ready.
  - in_ready = out_ready (back-to-back).
  - out_ready & in_valid: load_en=1, next state ROUND at ROUND_BASE, out_valid->0.
  - out_ready & ~in_valid: next state IDLE.
- Latency: accept at cycle T; round_en asserted T+1..T+NUM_ROUNDS with no stall; out_valid=1 from T+NUM_ROUNDS+1. Each stall cycle adds 1.
- abort (ROUND or DONE): next state IDLE, round_number=0, busy=0, out_valid=0, round_en=0 that cycle.
  - abort wins over stall and over a completing last round.
  - abort in DONE suppresses acceptance even if out_ready&in_valid.
  - abort in IDLE has no effect.
- round_en and load_en are never high in the same cycle.
- round_number never leaves the range [ROUND_BASE, ROUND_BASE+NUM_ROUNDS-1] while round_en=1.
- Async reset mid-permutation returns to IDLE immediately; no out_valid is produced for that block.

Decomposition:
- keccak_pkg holds:
  - state enum (IDLE/ROUND/DONE)
  - NUM_ROUNDS=24, ROUND_BASE=1, RW=5
  - lane width 64, state width 1600
- One sub-module is natural: keccak_round_counter, a loadable RW-bit counter with enable, a clear and a terminal-count flag. It is instantiated once; the FSM stays in the top.
- The round-constant ROM is instantiated by the datapath, not by this block.

Test Plan:
1. Reset, then one block: in_valid=1 at cycle 0 -> load_en at cycle 0; round_en cycles 1-24 with round_number 1..24; out_valid at cycle 25; ROM outputs are 0x1 at idx 1 and 0x8000000080008008 at idx 24.
2. Stall 3 cycles at round_number=10 -> round_en=0 and index held at 10 for 3 cycles; out_valid at cycle 28.
3. out_ready low 5 cycles in DONE -> out_valid stays 1 and in_ready stays 0; release with in_valid=1 -> load_en same cycle, next round_number=1, no IDLE cycle.
4. abort at round_number=24 together with stall=1 -> next cycle IDLE, out_valid=0, round_number=0; a new block is accepted the following cycle.
5. rst_n low at round_number=7 -> outputs clear asynchronously before the next clk edge; after release in_ready=1 and busy=0.
6. Random in_valid/out_ready/stall, 1000 blocks -> exactly 24 round_en per completed block; load_en and round_en never coincide; no out_valid drop without out_ready.
